// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the round-robin Gray-encoder arbiter.
package gray_arb_pkg;

  // Bits needed to index n items (minimum 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reset value of the last-grant pointer, so requester 0 wins first.
  function automatic int unsigned rst_ptr(input int unsigned n_req);
    return n_req - 1;
  endfunction

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

endpackage

// File: rtl/gray_enc.sv
// Purely combinational binary-to-Gray encoder.
module gray_enc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray encoder among N_REQ requesters.
// Optional per-requester saturating grant counters under GRAY_ARB_STATS_EN.
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned ID_W  = clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_gray,
  output logic [ID_W-1:0]          out_id,
  output logic                     busy
`ifdef GRAY_ARB_STATS_EN
  ,
  output logic [N_REQ*8-1:0]       grant_cnt
`endif
);

  localparam int unsigned RST_PTR = rst_ptr(N_REQ);

  out_state_t       state;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             can_accept;
  logic             transfer;
  logic [WIDTH-1:0] lane [N_REQ];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] sel_gray;

  for (genvar g = 0; g < N_REQ; g++) begin : g_lane
    assign lane[g] = req_data[g*WIDTH +: WIDTH];
  end

  // Scan last+1, last+2, ... modulo N_REQ; first valid requester wins.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = 32'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_any && req_valid[ID_W'(idx)]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'(idx);
      end
    end
  end

  assign out_valid  = (state == ST_FULL);
  assign can_accept = !out_valid || out_ready;
  // Gate with rst: the async reset empties the register, which would otherwise open can_accept.
  assign transfer   = grant_any && can_accept && !rst;
  assign req_ready  = transfer ? (N_REQ'(1) << grant_idx) : '0;
  assign busy       = (|req_valid) || out_valid;

  assign sel_data = lane[grant_idx];

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin  (sel_data),
    .gray (sel_gray)
  );

  // One-entry output register and its EMPTY/FULL state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_gray <= '0;
      out_id   <= '0;
      last     <= ID_W'(RST_PTR);
    end else begin
      if (transfer) begin
        out_gray <= sel_gray;
        out_id   <= grant_idx;
        last     <= grant_idx;
      end
      case (state)
        ST_EMPTY: if (transfer) state <= ST_FULL;
        ST_FULL:  if (out_ready && !transfer) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

`ifdef GRAY_ARB_STATS_EN
  // Per-requester transfer counts, saturating at 8'hFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (transfer) begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (grant_idx == ID_W'(i) && grant_cnt[i*8 +: 8] != 8'hFF)
          grant_cnt[i*8 +: 8] <= grant_cnt[i*8 +: 8] + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: driver pushes expected results, monitor pops on output handshake.
module tb_gray_conv_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ID_W  = 2;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] gray;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       out_gray;
  logic [ID_W-1:0]        out_id;
  logic                   busy;
`ifdef GRAY_ARB_STATS_EN
  logic [N_REQ*8-1:0]     grant_cnt;
`endif

  int   vec_cnt;
  int   err_cnt;
  exp_t q[$];
  exp_t mon_e;

  gray_conv_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .busy      (busy)
`ifdef GRAY_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input logic [7:0] d3);
    req_data = {d3, d2, d1, d0};
  endtask

  task automatic push(input logic [ID_W-1:0] id, input logic [WIDTH-1:0] gray);
    q.push_back('{id, gray});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
    end
  endtask

  // Monitor: a result presented with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL unexpected_output: got id %0d gray %0h, expected none", out_id, out_gray);
      end else begin
        mon_e = q.pop_front();
        chk("out_id", 32'(out_id), 32'(mon_e.id));
        chk("out_gray", 32'(out_gray), 32'(mon_e.gray));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, and no req_ready while rst is held even with requests pending.
    req_valid = 4'b1111;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray", 32'(out_gray), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick();
    rst = 1'b0;
    #1;
    chk("busy_idle", 32'(busy), 32'd0);

    // Single request from requester 0.
    set_data(8'hB5, 8'h00, 8'h00, 8'h00);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    push(2'd0, 8'hEF);
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'b0001);
    chk("busy_active", 32'(busy), 32'd1);
    tick();
    req_valid = '0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    drain();

    // All four valid after reset: 0,1,2,3 then wrap to 0.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    set_data(8'h00, 8'hFF, 8'h80, 8'h7F);
    req_valid = 4'b1111;
    begin
      logic [7:0] g_tab [4];
      g_tab[0] = 8'h00; g_tab[1] = 8'h80; g_tab[2] = 8'hC0; g_tab[3] = 8'h40;
      for (int i = 0; i < 5; i++) begin
        push(ID_W'(i % 4), g_tab[i % 4]);
        #1;
        chk("t2_req_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
        tick();
      end
    end
    req_valid = '0;
    drain();

    // After id 2 is granted, requester 3 beats requester 0.
    set_data(8'hAA, 8'h00, 8'h0A, 8'h55);
    req_valid = 4'b0100;
    push(2'd2, 8'h0F);
    #1;
    chk("t3_grant2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1001;
    push(2'd3, 8'h7F);
    #1;
    chk("t3_grant3", 32'(req_ready), 32'b1000);
    tick();
    push(2'd0, 8'hFF);
    #1;
    chk("t3_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    drain();

    // Backpressure: FULL with 03->02 held for 5 cycles while everyone requests.
    out_ready = 1'b0;
    set_data(8'h11, 8'h03, 8'h33, 8'h44);
    req_valid = 4'b0010;
    push(2'd1, 8'h02);
    #1;
    chk("t4_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      req_data = {$urandom, $urandom};
      #1;
      chk("t4_bp_ready", 32'(req_ready), 32'd0);
      chk("t4_bp_valid", 32'(out_valid), 32'd1);
      chk("t4_bp_gray", 32'(out_gray), 32'h02);
      chk("t4_bp_id", 32'(out_id), 32'd1);
      tick();
    end
    set_data(8'h11, 8'h03, 8'h33, 8'h44);
    out_ready = 1'b1;
    push(2'd2, 8'h2A);
    #1;
    chk("t4_release_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    drain();

    // Async reset while FULL discards the entry; requester 0 then wins.
    out_ready = 1'b0;
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b1111;
    #1;
    chk("t5_full", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    push(2'd0, 8'h19);
    #1;
    chk("t5_after_rst", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    drain();

`ifdef GRAY_ARB_STATS_EN
    // 300 grants to requester 1 saturate only lane 1.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    set_data(8'h00, 8'h01, 8'h00, 8'h00);
    req_valid = 4'b0010;
    for (int i = 0; i < 300; i++) begin
      push(2'd1, 8'h01);
      tick();
    end
    req_valid = '0;
    drain();
    chk("stats_sat", 32'(grant_cnt), 32'h0000FF00);
    rst = 1'b1;
    #1;
    chk("stats_rst", 32'(grant_cnt), 32'd0);
    tick();
    rst = 1'b0;
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
Round-robin arbiter that shares one binary-to-Gray encoder among N_REQ requesters. Each requester offers a WIDTH-bit binary word over a valid/ready handshake. The block grants one requester per cycle, encodes its word, and holds the Gray result and requester ID in a one-entry output register with its own valid/ready handshake. It sits between pointer/counter sources (FIFO pointers, position counters) and their Gray-coded consumers.

Parameters:
N_REQ, 4, number of requesters (2..16)
WIDTH, 8, data width of binary input and Gray output (>=2)
ID_W, clog2(N_REQ), width of out_id (derived; not overridden)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  per-requester request valid
req_data  in  N_REQ*WIDTH  flattened binary words; requester i at [i*WIDTH +: WIDTH]
req_ready  out  N_REQ  per-requester accept, one-hot or zero
out_valid  out  1  output register holds a result
out_ready  in  1  downstream accepts result
out_gray  out  WIDTH  Gray code of the accepted word
out_id  out  ID_W  index of the requester that produced out_gray
busy  out  1  any req_valid high or out_valid high

Behaviour:
- Reset (async, immediate): out_valid=0, out_gray=0, out_id=0, last-grant pointer=N_REQ-1 (requester 0 has top priority after reset).
- can_accept = !out_valid | out_ready (combinational).
- Grant: first i with req_valid[i]=1, scanning last+1, last+2, ... modulo N_REQ. Wrap-around: last=N_REQ-1 scans from 0.
- req_ready[i] = grant[i] & can_accept. Combinational from req_valid, pointer, out_valid, out_ready. At most one bit set.
- Transfer on requester i: req_valid[i] & req_ready[i] at a rising edge.
- On transfer: out_gray <= G(req_data[i]), where G(b)[WIDTH-1]=b[WIDTH-1] and G(b)[k]=b[k]^b[k+1]. Also out_id <= i, out_valid <= 1, last <= i.
- Latency: 1 cycle from transfer to out_valid. Throughput: 1 result per cycle while out_ready=1.
- Output state machine, 2 states:
  - EMPTY (out_valid=0): transfer -> FULL; otherwise stay.
  - FULL (out_valid=1): out_ready & transfer -> FULL with new data. out_ready & no transfer -> EMPTY. !out_ready -> FULL, held.
- Backpressure: while FULL and out_ready=0, out_gray and out_id are held stable, all req_ready=0, and the pointer is frozen.
- The pointer updates only on a transfer. A requester that drops req_valid before it is granted loses nothing, and no state changes.
- req_data is sampled only at transfer. It may change freely otherwise.
- Single active requester: granted every cycle (no forced idle).
- Reset mid-operation: a held result is discarded, the pointer returns to N_REQ-1, and no req_ready is asserted while rst=1.
- No X propagation: unused req_data lanes do not affect the outputs.

Optional Feature:
Macro GRAY_ARB_STATS_EN.
- Defined: adds output port grant_cnt, N_REQ*8 bits. Each lane holds an 8-bit saturating count of transfers for that requester. A lane increments on transfer, sticks at 8'hFF, and is cleared to 0 by rst.
- Not defined: port and counters are absent. The core behaviour is identical in both cases.

Decomposition:
- Package gray_arb_pkg:
  - clog2 function for ID_W.
  - RST_PTR constant (N_REQ-1).
  - Output state encoding: ST_EMPTY=1'b0, ST_FULL=1'b1.
- Sub-module gray_enc (WIDTH-parameterized, purely combinational binary-to-Gray).
  - Instantiated once on the granted lane's data. This single instance is the shared resource.
- Round-robin grant logic stays inline.

Test Plan:
- Reset, then requester 0 only with 8'hB5 and out_ready=1 -> req_ready=4'b0001 the same cycle; next cycle out_valid=1, out_gray=8'hEF, out_id=0.
- All four requesters valid with data 8'h00, 8'hFF, 8'h80, 8'h7F, out_ready=1 -> outputs on consecutive cycles in order id 0,1,2,3 with gray 8'h00, 8'h80, 8'hC0, 8'h40; the fifth grant wraps to id 0.
- After id 2 is granted, requesters 0 and 3 are valid -> requester 3 is granted before 0.
- out_ready=0 for 5 cycles while FULL (8'h03 -> 8'h02), with all requesters valid -> req_ready=0, and out_gray/out_id stay stable for all 5 cycles. Raising out_ready drains the entry and grants the next requester in the same cycle.
- Assert rst asynchronously mid-cycle while FULL -> out_valid=0 immediately; after release, requester 0 wins over 1, 2 and 3.
- With GRAY_ARB_STATS_EN: 300 grants to requester 1 -> grant_cnt lane 1 = 8'hFF and the other lanes are 0; after rst, all lanes are 0.
